// File: rtl/send_unscript_cmd.sv
// Unscripted-mode command transmitter: captures button edges, serialises them
// as one-byte op commands over a valid/ready link, with idle heartbeats.
module send_unscript_cmd #(
  parameter int GAP_CYCLES       = 16,
  parameter int HEARTBEAT_CYCLES = 50_000_000,
  parameter int CNT_W            = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] cmd_req,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [7:0] pending,
  output logic       busy,
  output logic [7:0] sent_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       HEARTBEAT_BYTE = 8'h01;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_req_q;
  logic [7:0]       pending_q, pending_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       sent_count_q, sent_count_d;
  logic             tx_valid_q, tx_valid_d;

  logic [7:0]       edges;
  logic [7:0]       sel_onehot;
  logic [3:0]       sel_op;

  // Lowest pending bit wins; op code is bit index + 1 so op 0 stays the heartbeat.
  always_comb begin
    sel_onehot = pending_q & (~pending_q + 8'd1);
    sel_op     = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) sel_op = 4'(i + 1);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    sent_count_d = sent_count_q;
    edges        = enable ? (cmd_req & ~cmd_req_q) : 8'd0;
    pending_d    = pending_q | edges;

    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (!enable) begin
          cnt_d = '0;
        end else if (pending_q != 8'd0) begin
          // A fresh edge on the bit being cleared is re-ORed in, so it is not lost.
          tx_data_d  = {2'b00, sel_op, 2'b01};
          pending_d  = (pending_q & ~sel_onehot) | edges;
          cnt_d      = '0;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else if (cnt_q == HB_LAST) begin
          tx_data_d  = HEARTBEAT_BYTE;
          cnt_d      = '0;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SEND: begin
        tx_valid_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d   = 1'b0;
          sent_count_d = sent_count_q + 8'd1;
          cnt_d        = '0;
          state_d      = GAP;
        end
      end

      GAP: begin
        tx_valid_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        tx_valid_d = 1'b0;
        cnt_d      = '0;
        state_d    = IDLE;
      end
    endcase

    if (!enable) pending_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_req_q    <= 8'd0;
      pending_q    <= 8'd0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      sent_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_req_q    <= cmd_req;
      pending_q    <= pending_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign pending    = pending_q;
  assign busy       = (state_q != IDLE);
  assign sent_count = sent_count_q;

endmodule

// File: doc/send_unscript_cmd.md
Name: send_unscript_cmd

Overview:
- Transmit-side counterpart of the unscripted-mode feedback path.
- Turns player button presses into one-byte operation commands and hands them to the UART transmitter over a valid/ready handshake.
- Uses the same byte framing the feedback path decodes: bits [1:0] = 2'b01 tag the unscripted channel, bits [5:2] carry the payload.
- Emits a no-op heartbeat byte when idle, so the game side knows the board is alive.

Parameters:
- GAP_CYCLES, 16, clk cycles of enforced silence after each accepted byte (minimum 1).
- HEARTBEAT_CYCLES, 50_000_000, idle clk cycles before a heartbeat byte is sent (minimum 2).
- CNT_W, 26, width of the gap/heartbeat counter; must hold max(GAP_CYCLES, HEARTBEAT_CYCLES).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  1 = unscripted mode active; 0 = script mode, block silent.
- cmd_req  input  8  operation buttons, already synchronised/debounced, level-high; bit i = operation i.
- tx_ready  input  1  UART transmitter can accept a byte this cycle.
- tx_valid  output  1  tx_data holds a byte to send.
- tx_data  output  8  byte to send.
- pending  output  8  per-operation "captured, not yet sent" flags.
- busy  output  1  FSM not in IDLE.
- sent_count  output  8  bytes accepted by the transmitter, wraps 255->0.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM = IDLE, counter = 0, edge-detect history = 0.
- Byte format: tx_data = {2'b00, op[3:0], 2'b01}.
  - Operation bit i sends op = i+1, i.e. 1..8.
  - op = 0 is the heartbeat/no-op, byte 8'h01.
- Edge capture: every cycle, cmd_req & ~cmd_req_q is ORed into pending; cmd_req_q <= cmd_req.
  - A held button produces exactly one capture.
  - A new edge on an already-pending bit merges; it is not counted twice.
  - When enable=0: pending forced to 0, no captures, cmd_req_q still tracks cmd_req.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - Counter increments each cycle.
  - If enable=1 and pending!=0: select the lowest set bit k, load tx_data with op k+1, clear pending[k] in that same cycle, counter=0, go to SEND.
  - If the same-cycle edge on bit k coincides with this load, pending[k] stays set, so a new press is never lost.
  - Else if enable=1 and counter reaches HEARTBEAT_CYCLES-1: load 8'h01, counter=0, go to SEND.
  - If enable=0: counter held at 0.
- SEND:
  - tx_valid=1; tx_data stable until accepted.
  - On tx_ready=1, the byte is accepted: next cycle tx_valid=0, sent_count+1, counter=0, go to GAP.
  - enable falling during SEND does not abort; the byte completes.
- GAP:
  - tx_valid=0; counter counts to GAP_CYCLES-1, then go to IDLE with counter=0.
  - Captures continue during GAP.
- Latency: an edge on cmd_req sampled in cycle t, with the FSM in IDLE, gives tx_valid=1 at cycle t+2.
- Heartbeat counter restarts after every sent byte, so heartbeats only occur after HEARTBEAT_CYCLES of true idleness.
- busy = (state != IDLE).
- Reset mid-SEND: tx_valid drops immediately (async); the partially offered byte is dropped; pending is cleared.

Test Plan:
- Reset then idle: rst pulse, enable=1, cmd_req=0, tx_ready=1, HEARTBEAT_CYCLES=20 -> all outputs 0 during reset; first tx_data=8'h01 with tx_valid at 20th cycle after reset release; sent_count=1.
- Single press: pulse cmd_req[2] for 5 cycles -> exactly one byte 8'h0D (op 3); pending[2] 1 for one cycle only; no repeat while held.
- Simultaneous presses: cmd_req=8'b1000_0001 in one cycle, tx_ready=1, GAP_CYCLES=4 -> bytes 8'h05 then 8'h21, separated by ≥4 cycles of tx_valid=0.
- Backpressure: press bit 0, tx_ready=0 for 10 cycles -> tx_valid=1 and tx_data=8'h05 stable all 10 cycles; accepted on tx_ready=1; sent_count increments once.
- Script mode: enable=0, presses on bits 1 and 3 -> no tx_valid, pending=0, no heartbeat; raising enable with buttons held produces no bytes.
- Reset mid-SEND: press bit 4, tx_ready=0, assert rst while tx_valid=1 -> tx_valid=0 same cycle, pending=0; after release, no byte sent until a new edge.
